// File: rtl/mul5_recombine_serial.sv
// mul5_recombine_serial
//
// Digit-serial reconstruction of a dividend from a divide-by-5 result:
//   x = q*5 + r
// q is consumed LSB-first, CHUNK bits per cycle. A 3-bit carry ripples
// between chunks and plays the same role as the running remainder in the
// matching serial divider.
//
// Build option:
//   MUL5_RECOMBINE_OVF_CHECK_EN  defined   -> ovf = (final carry != 0)
//                                undefined -> ovf tied to 0, compare removed
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   q/r valid
//   in_ready   block idle and able to accept an operand
//   q [W]      quotient
//   r [3]      remainder, legal 0..4
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   x [W]      low W bits of q*5 + r
//   ovf        q*5 + r does not fit in W bits
//   err_rem    captured r was greater than 4
//
// Parameters: W must be a multiple of CHUNK, and W/CHUNK must be at least 2.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid
// RUN   | one chunk per cycle, N steps
// DONE  | out_valid high, result held until out_ready

module mul5_recombine_serial #(
  parameter int W     = 64,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] q,
  input  logic [2:0]   r,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x,
  output logic         ovf,
  output logic         err_rem
);

  localparam int N     = W / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]     q_sh;
  logic [W-1:0]     x_sh;
  logic [2:0]       carry;
  logic [CNT_W-1:0] step;
  logic             err_q;

  logic [CHUNK+2:0] qc_ext;
  logic [CHUNK+2:0] p;
  logic [2:0]       carry_nxt;
  logic             accept;
  logic             last_step;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (last_step) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs, decoded from the state register only so no input
  // reaches an output combinationally
  // ------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (state == RUN) && (step == LAST_STEP);

  // ------------------------------------------------------------------
  // One recombination step: p = chunk*5 + carry, computed as
  // (chunk<<2) + chunk + carry. With carry <= 7 the maximum is
  // 5*2^CHUNK + 2, which fits in CHUNK+3 bits, and the resulting carry
  // never exceeds 5, so 3 carry bits lose nothing even for r = 5..7.
  // ------------------------------------------------------------------
  always_comb begin
    qc_ext    = {3'b000, q_sh[CHUNK-1:0]};
    p         = (qc_ext << 2) + qc_ext + {{CHUNK{1'b0}}, carry};
    carry_nxt = p[CHUNK+2:CHUNK];
  end

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sh  <= '0;
      x_sh  <= '0;
      carry <= 3'd0;
      step  <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        q_sh  <= q;
        carry <= r;
        step  <= '0;
        err_q <= (r > 3'd4);
      end else if (state == RUN) begin
        q_sh  <= q_sh >> CHUNK;
        // Result chunks enter from the MSB side; after N steps the first
        // chunk has reached bit 0 and x_sh holds the full low W bits.
        x_sh  <= {p[CHUNK-1:0], x_sh[W-1:CHUNK]};
        carry <= carry_nxt;
        step  <= step + 1'b1;
      end
    end
  end

  assign x       = x_sh;
  assign err_rem = err_q;

`ifdef MUL5_RECOMBINE_OVF_CHECK_EN
  logic ovf_q;

  // Whatever carry remains after the last chunk is the part of q*5 + r
  // above bit W-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (last_step) begin
      ovf_q <= (carry_nxt != 3'd0);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
